segment_display_arbiter: RTL and testbench
==========================================

Name: segment_display_arbiter

Overview:
- Shares the 8-digit multiplexed seven-segment display between NUM_REQUESTERS independent producers, e.g. switch echo, counter and status. Uses a request/grant handshake with round-robin time slicing.
- Sits directly upstream of the seven-segment controller/encoder path. Drives the 32-bit digit data, decimal-point mask and blank flag that path consumes.
- All outputs are registered, so the display never shows a mix of two requesters' data.

Parameters:
NUM_REQUESTERS, 4, number of requester channels (2..8)
MIN_HOLD_CYCLES, 100000000, clock cycles an owner keeps the display before it can be preempted by a pending requester (1 s at 100 MHz)
HOLD_WIDTH, 27, width of hold counter; must satisfy 2^HOLD_WIDTH > MIN_HOLD_CYCLES

Ports:
clock  input  1  system clock, 100 MHz nominal
reset  input  1  asynchronous, active-high reset
request  input  NUM_REQUESTERS  level request per requester; held high while it wants the display
requestData  input  32*NUM_REQUESTERS  eight 4-bit digits per requester; requester i occupies bits [32*i +: 32]
requestPoints  input  8*NUM_REQUESTERS  decimal-point enables per requester, [8*i +: 8]
grant  output  NUM_REQUESTERS  one-hot grant, all zero when no owner
owner  output  3  index of current owner, valid only when grant != 0
displayData  output  32  data forwarded to the seven-segment controller
displayPoints  output  8  point mask forwarded to the controller
displayBlank  output  1  high = controller must disable all digits

Behaviour:
- Reset (async, immediate), all values held until reset deasserts:
  - state = IDLE; grant = 0; owner = 0; rrPointer = 0; holdCount = 0
  - displayData = 0; displayPoints = 0; displayBlank = 1
- States: IDLE, OWNED, SWITCH.
- IDLE:
  - blank = 1, grant = 0.
  - If request != 0, select a winner and go to OWNED next cycle.
  - grant, owner, displayBlank = 0 and the first displayData all update on that same edge: 1-cycle latency from request to grant.
- Winner selection (round-robin): first set request bit scanning upward from rrPointer, wrapping at NUM_REQUESTERS-1 -> 0.
- On grant: rrPointer <= (winner + 1) mod NUM_REQUESTERS; holdCount <= 0.
- OWNED:
  - Every cycle: displayData <= requestData[owner]; displayPoints <= requestPoints[owner]. Live data, 1-cycle lag.
  - holdCount increments, saturating at MIN_HOLD_CYCLES-1.
  - Owner drops request -> SWITCH next cycle, regardless of holdCount.
  - Owner still requesting, another request bit set, and holdCount == MIN_HOLD_CYCLES-1 -> SWITCH (preemption).
  - Owner still requesting and no other request -> stay OWNED indefinitely; holdCount stays saturated.
- SWITCH: exactly one cycle.
  - grant = 0; displayBlank = 1; displayData/displayPoints hold their last values.
  - Next cycle: if request != 0, select a winner and enter OWNED; otherwise go to IDLE.
- Simultaneous events:
  - Owner drop and preemption condition in the same cycle are treated as a drop.
  - A requester deasserting in the same cycle it would have been selected is not granted.
- Single requester that drops and immediately re-raises: still passes through SWITCH, so it sees a 1-cycle gap in grant.
- Requests on index >= NUM_REQUESTERS do not exist; owner upper bits are 0.
- Invariants: grant is always one-hot or zero. displayBlank == (grant == 0) at every cycle boundary.

Optional Feature:
- Macro: SEGMENT_ARBITER_FIXED_PRIORITY_EN.
- Defined:
  - Winner selection is fixed priority; lowest set index wins. rrPointer is removed.
  - Preemption in OWNED occurs only when a lower-index requester is pending and holdCount == MIN_HOLD_CYCLES-1.
  - Higher-index pending requests never preempt.
- Undefined: round-robin behaviour as above.

Test Plan:
- Defaults are MIN_HOLD_CYCLES=8, NUM_REQUESTERS=4.
- Reset: assert reset mid-OWNED (owner=2) -> same cycle grant=0, displayBlank=1, displayData=0; after release with request=0, state stays IDLE.
- Single grant: request=4'b0010, requestData[1]=32'h0000BEEF -> next edge grant=4'b0010, owner=1, displayBlank=0, displayData=32'h0000BEEF; change data to 32'h00001234 -> displayData follows 1 cycle later.
- Time slice: request=4'b0011 held -> owner 0 granted; grant held for 8 cycles; 1 SWITCH cycle with blank=1; then owner 1 granted; then owner 0 again. Checks round-robin order 0,1,0,1.
- Voluntary release: owner 3 drops request after 2 cycles while request[0]=1 -> SWITCH next cycle, then grant=4'b0001 without waiting for MIN_HOLD.
- Wrap-around: rrPointer=3 (after owner 2), request=4'b1001 -> owner 3 granted; next arbitration with 4'b1001 -> owner 0.
- With SEGMENT_ARBITER_FIXED_PRIORITY_EN: owner 2 active, request[3] pending 20 cycles -> no preemption; request[0] raised -> preempted once holdCount reaches 7; grant=4'b0001 after 1 blank cycle.

Source files
------------

// File: rtl/segment_display_arbiter.sv
// segment_display_arbiter: shares one 8-digit seven-segment display between
// NUM_REQUESTERS producers with a request/grant handshake, a minimum hold
// time per owner and a one-cycle blanking gap on every ownership change.
// Optional build macro: SEGMENT_ARBITER_FIXED_PRIORITY_EN selects fixed
// priority (lowest index wins) instead of round-robin arbitration.
module segment_display_arbiter #(
  parameter int unsigned NUM_REQUESTERS  = 4,
  parameter int unsigned MIN_HOLD_CYCLES = 100000000,
  parameter int unsigned HOLD_WIDTH      = 27
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQUESTERS-1:0]      request,
  input  logic [32*NUM_REQUESTERS-1:0]   requestData,
  input  logic [8*NUM_REQUESTERS-1:0]    requestPoints,
  output logic [NUM_REQUESTERS-1:0]      grant,
  output logic [2:0]                     owner,
  output logic [31:0]                    displayData,
  output logic [7:0]                     displayPoints,
  output logic                           displayBlank
);

  localparam int unsigned DIGITS_W = 32;
  localparam int unsigned POINTS_W = 8;
  localparam int unsigned IDX_W    = 3;
  localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = HOLD_WIDTH'(MIN_HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_REQUESTERS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWNED  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t                state;
  logic [HOLD_WIDTH-1:0] hold_count;
`ifndef SEGMENT_ARBITER_FIXED_PRIORITY_EN
  logic [IDX_W-1:0]      rr_pointer;
`endif

  logic                      winner_valid;
  logic [IDX_W-1:0]          winner;
  logic [NUM_REQUESTERS-1:0] winner_onehot;
  logic [DIGITS_W-1:0]       winner_data;
  logic [POINTS_W-1:0]       winner_points;
  logic                      owner_request;
  logic                      preempt_pending;
  logic [DIGITS_W-1:0]       owner_data;
  logic [POINTS_W-1:0]       owner_points;
  logic                      hold_done;

`ifdef SEGMENT_ARBITER_FIXED_PRIORITY_EN
  // Winner selection: lowest set request index wins.
  always_comb begin
    winner_valid = 1'b0;
    winner       = '0;
    for (int i = int'(NUM_REQUESTERS) - 1; i >= 0; i--) begin
      if (request[i]) begin
        winner_valid = 1'b1;
        winner       = IDX_W'(i);
      end
    end
  end
`else
  logic             upper_valid;
  logic [IDX_W-1:0] upper_idx;
  logic             lower_valid;
  logic [IDX_W-1:0] lower_idx;

  // Winner selection: first request at or above rr_pointer, else wrap to the lowest request.
  always_comb begin
    upper_valid = 1'b0;
    upper_idx   = '0;
    lower_valid = 1'b0;
    lower_idx   = '0;
    for (int i = 0; i < int'(NUM_REQUESTERS); i++) begin
      if (request[i]) begin
        if (!lower_valid) begin
          lower_valid = 1'b1;
          lower_idx   = IDX_W'(i);
        end
        if (!upper_valid && (IDX_W'(i) >= rr_pointer)) begin
          upper_valid = 1'b1;
          upper_idx   = IDX_W'(i);
        end
      end
    end
    winner_valid = lower_valid;
    winner       = upper_valid ? upper_idx : lower_idx;
  end
`endif

  // Winner payload mux and one-hot grant vector.
  always_comb begin
    winner_onehot = '0;
    winner_data   = '0;
    winner_points = '0;
    for (int i = 0; i < int'(NUM_REQUESTERS); i++) begin
      if (IDX_W'(i) == winner) begin
        winner_onehot[i] = 1'b1;
        winner_data      = requestData[DIGITS_W*i +: DIGITS_W];
        winner_points    = requestPoints[POINTS_W*i +: POINTS_W];
      end
    end
  end

  // Current owner's live request/payload and whether a competitor may preempt it.
  always_comb begin
    owner_request   = 1'b0;
    preempt_pending = 1'b0;
    owner_data      = '0;
    owner_points    = '0;
    for (int i = 0; i < int'(NUM_REQUESTERS); i++) begin
      if (IDX_W'(i) == owner) begin
        owner_request = request[i];
        owner_data    = requestData[DIGITS_W*i +: DIGITS_W];
        owner_points  = requestPoints[POINTS_W*i +: POINTS_W];
      end else if (request[i]) begin
`ifdef SEGMENT_ARBITER_FIXED_PRIORITY_EN
        if (IDX_W'(i) < owner) preempt_pending = 1'b1;
`else
        preempt_pending = 1'b1;
`endif
      end
    end
  end

  assign hold_done = (hold_count == HOLD_MAX);

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      owner         <= '0;
      hold_count    <= '0;
      displayData   <= '0;
      displayPoints <= '0;
      displayBlank  <= 1'b1;
`ifndef SEGMENT_ARBITER_FIXED_PRIORITY_EN
      rr_pointer    <= '0;
`endif
    end else begin
      case (state)
        IDLE, SWITCH: begin
          // Grant, owner, unblank and first payload all land on the same edge.
          if (winner_valid) begin
            state         <= OWNED;
            grant         <= winner_onehot;
            owner         <= winner;
            displayBlank  <= 1'b0;
            displayData   <= winner_data;
            displayPoints <= winner_points;
            hold_count    <= '0;
`ifndef SEGMENT_ARBITER_FIXED_PRIORITY_EN
            rr_pointer    <= (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
`endif
          end else begin
            state <= IDLE;
          end
        end
        OWNED: begin
          displayData   <= owner_data;
          displayPoints <= owner_points;
          if (!hold_done) hold_count <= hold_count + HOLD_WIDTH'(1);
          // A drop wins over preemption; both leave through the blank SWITCH cycle.
          if (!owner_request || (preempt_pending && hold_done)) begin
            state        <= SWITCH;
            grant        <= '0;
            displayBlank <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          grant        <= '0;
          displayBlank <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_segment_display_arbiter.sv
// Testbench for segment_display_arbiter: directed scenarios followed by
// randomized request/data traffic, all checked against a behavioural model.
// Honours SEGMENT_ARBITER_FIXED_PRIORITY_EN the same way the design does.
module tb_segment_display_arbiter;

  localparam int N   = 4;
  localparam int MIN = 8;
  localparam int HW  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  request;
  logic [32*N-1:0] request_data;
  logic [8*N-1:0]  request_points;
  logic [N-1:0]  grant;
  logic [2:0]    owner;
  logic [31:0]   display_data;
  logic [7:0]    display_points;
  logic          display_blank;

  logic [31:0] rd [N];
  logic [7:0]  rp [N];

  int total  = 0;
  int passed = 0;

  // Reference model state
  bit          m_owned;
  int          m_owner;
  int          m_hold;
  int          m_rr;
  logic [31:0] m_data;
  logic [7:0]  m_pts;

  segment_display_arbiter #(
    .NUM_REQUESTERS (N),
    .MIN_HOLD_CYCLES(MIN),
    .HOLD_WIDTH     (HW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .request      (request),
    .requestData  (request_data),
    .requestPoints(request_points),
    .grant        (grant),
    .owner        (owner),
    .displayData  (display_data),
    .displayPoints(display_points),
    .displayBlank (display_blank)
  );

  always #5 clock = ~clock;

  always_comb begin
    request_data   = '0;
    request_points = '0;
    for (int i = 0; i < N; i++) begin
      request_data[32*i +: 32] = rd[i];
      request_points[8*i +: 8] = rp[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int rr);
`ifdef SEGMENT_ARBITER_FIXED_PRIORITY_EN
    for (int k = 0; k < N; k++) if (r[k]) return k;
`else
    for (int k = 0; k < N; k++) begin
      int idx = (rr + k) % N;
      if (r[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_owned = 1'b0;
    m_owner = 0;
    m_hold  = 0;
    m_rr    = 0;
    m_data  = '0;
    m_pts   = '0;
  endtask

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_step();
    if (reset) begin
      model_reset();
      return;
    end
    if (m_owned) begin
      bit others = 1'b0;
      bit leave;
      for (int k = 0; k < N; k++) begin
`ifdef SEGMENT_ARBITER_FIXED_PRIORITY_EN
        if (k < m_owner && request[k]) others = 1'b1;
`else
        if (k != m_owner && request[k]) others = 1'b1;
`endif
      end
      leave  = !request[m_owner] || (others && m_hold == MIN - 1);
      m_data = rd[m_owner];
      m_pts  = rp[m_owner];
      if (m_hold < MIN - 1) m_hold++;
      if (leave) m_owned = 1'b0;
    end else begin
      int w = pick(request, m_rr);
      if (w >= 0) begin
        m_owned = 1'b1;
        m_owner = w;
        m_hold  = 0;
        m_rr    = (w + 1) % N;
        m_data  = rd[w];
        m_pts   = rp[w];
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = m_owned ? N'(1 << m_owner) : '0;
    chk({tag, "/grant"}, 32'(grant), 32'(eg));
    chk({tag, "/blank"}, 32'(display_blank), 32'(!m_owned));
    chk({tag, "/data"}, display_data, m_data);
    chk({tag, "/points"}, 32'(display_points), 32'(m_pts));
    if (m_owned) chk({tag, "/owner"}, 32'(owner), 32'(m_owner));
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    model_step();
    #1;
    check_model(tag);
  endtask

  initial begin
    reset   = 1'b1;
    request = '0;
    for (int i = 0; i < N; i++) begin
      rd[i] = 32'h1111_1111 * (i + 1);
      rp[i] = 8'(8'h10 + i);
    end
    model_reset();
    #12;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_blank", 32'(display_blank), 32'h1);
    chk("reset_data", display_data, 32'h0);
    chk("reset_owner", 32'(owner), 32'h0);
    reset = 1'b0;

`ifndef SEGMENT_ARBITER_FIXED_PRIORITY_EN
    // Single grant with live data follow
    request = 4'b0010;
    rd[1]   = 32'h0000_BEEF;
    tick("sg");
    chk("sg_grant", 32'(grant), 32'h2);
    chk("sg_owner", 32'(owner), 32'h1);
    chk("sg_blank", 32'(display_blank), 32'h0);
    chk("sg_data", display_data, 32'h0000_BEEF);
    rd[1] = 32'h0000_1234;
    tick("sg_follow");
    chk("sg_follow_data", display_data, 32'h0000_1234);
    request = '0;
    tick("sg_drop");
    chk("sg_drop_blank", 32'(display_blank), 32'h1);
    tick("sg_idle");

    // Time slice 0,1,0 with two requesters held high
    request = 4'b0011;
    tick("ts");
    chk("ts_first", 32'(grant), 32'h1);
    for (int c = 0; c < MIN - 1; c++) begin
      tick("ts_hold0");
      chk("ts_hold0_grant", 32'(grant), 32'h1);
    end
    tick("ts_sw0");
    chk("ts_sw0_grant", 32'(grant), 32'h0);
    chk("ts_sw0_blank", 32'(display_blank), 32'h1);
    tick("ts_second");
    chk("ts_second_grant", 32'(grant), 32'h2);
    for (int c = 0; c < MIN - 1; c++) tick("ts_hold1");
    tick("ts_sw1");
    chk("ts_sw1_grant", 32'(grant), 32'h0);
    tick("ts_third");
    chk("ts_third_grant", 32'(grant), 32'h1);
    request = '0;
    tick("ts_drop");
    tick("ts_idle");

    // Voluntary release before the hold time expires
    request = 4'b1001;
    tick("vr");
    chk("vr_grant3", 32'(grant), 32'h8);
    tick("vr_hold");
    request = 4'b0001;
    tick("vr_sw");
    chk("vr_sw_grant", 32'(grant), 32'h0);
    tick("vr_next");
    chk("vr_next_grant", 32'(grant), 32'h1);
    request = '0;
    tick("vr_drop");
    tick("vr_idle");

    // Round-robin wrap-around from pointer 3
    request = 4'b0100;
    tick("wr_a");
    chk("wr_a_grant", 32'(grant), 32'h4);
    request = '0;
    tick("wr_a_drop");
    tick("wr_a_idle");
    request = 4'b1001;
    tick("wr_b");
    chk("wr_b_grant", 32'(grant), 32'h8);
    request = '0;
    tick("wr_b_drop");
    tick("wr_b_idle");
    request = 4'b1001;
    tick("wr_c");
    chk("wr_c_grant", 32'(grant), 32'h1);
    request = '0;
    tick("wr_c_drop");
    tick("wr_c_idle");
`else
    // Fixed priority: higher index never preempts, lower index does after the hold
    request = 4'b0100;
    tick("fp");
    chk("fp_grant2", 32'(grant), 32'h4);
    request = 4'b1100;
    for (int c = 0; c < 20; c++) begin
      tick("fp_hold");
      chk("fp_hold_grant", 32'(grant), 32'h4);
    end
    request = 4'b1101;
    tick("fp_sw");
    chk("fp_sw_grant", 32'(grant), 32'h0);
    chk("fp_sw_blank", 32'(display_blank), 32'h1);
    tick("fp_low");
    chk("fp_low_grant", 32'(grant), 32'h1);
    request = '0;
    tick("fp_drop");
    tick("fp_idle");
`endif

    // Asynchronous reset in the middle of ownership by requester 2
    rd[2]   = 32'hCAFE_0002;
    request = 4'b0100;
    tick("rs");
    chk("rs_grant2", 32'(grant), 32'h4);
    tick("rs_own");
    reset = 1'b1;
    #1;
    chk("rs_async_grant", 32'(grant), 32'h0);
    chk("rs_async_blank", 32'(display_blank), 32'h1);
    chk("rs_async_data", display_data, 32'h0);
    model_reset();
    tick("rs_held");
    tick("rs_held");
    reset   = 1'b0;
    request = '0;
    for (int c = 0; c < 3; c++) begin
      tick("rs_idle");
      chk("rs_idle_grant", 32'(grant), 32'h0);
      chk("rs_idle_blank", 32'(display_blank), 32'h1);
    end

    // Randomized traffic: sticky requests with occasional toggles and data churn
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(7) == 0) request[k] = ~request[k];
        if ($urandom_range(3) == 0) rd[k] = $urandom;
        if ($urandom_range(3) == 0) rp[k] = 8'($urandom);
      end
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
